// File: rtl/upower_loader_pkg.sv
// Shared definitions for the instruction-memory image loader: FSM state
// encoding and the byte-level layout of a program image.
package upower_loader_pkg;

    // Loader FSM states, 3-bit encoded.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CNT_HI  = 3'd1,
        CNT_LO  = 3'd2,
        PAYLOAD = 3'd3,
        CHECK   = 3'd4,
        DONE    = 3'd5,
        ERROR   = 3'd6
    } loader_state_e;

    // Image layout: 2-byte word count, 4 bytes per word, 1 checksum byte.
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int CKSUM_BYTES    = 1;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer. Shifts accepted bytes in MSB first and
// flags the cycle in which the 4th byte of a word arrives; the assembled
// word is presented combinationally in that same cycle.
module byte_packer
    import upower_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [23:0] shift_q;
    logic [1:0]  count_q;

    assign word_valid = byte_valid && (count_q == LAST_BYTE);
    assign word       = {shift_q, byte_data};

    // Shift register and byte position; the counter wraps 3 -> 0 per word.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values and simulation matches the flops.
        if (reset || clear) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (byte_valid) begin
            shift_q <= {shift_q[15:0], byte_data};
            count_q <= count_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-serial program image loader. Parses count / payload / checksum,
// writes 32-bit words to instruction memory from address 0 and holds the
// core until a complete, checksum-verified image is in place.
module imem_loader
    import upower_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    localparam logic [16:0] DEPTH_EXT = 17'(DEPTH);

    loader_state_e     state_q, state_d;
    logic [15:0]       count_q;
    logic [ADDR_W-1:0] word_idx_q;
    logic [7:0]        cksum_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic              xfer;
    logic              start_ok;
    logic              pack_valid;
    logic              word_valid;
    logic [31:0]       word;
    logic [15:0]       count_n;
    logic              last_word;

    // Readiness is a pure function of state so the source sees no
    // combinational path from its own valid.
    assign in_ready   = (state_q == CNT_HI) || (state_q == CNT_LO) ||
                        (state_q == PAYLOAD) || (state_q == CHECK);
    assign xfer       = in_valid && in_ready;
    assign start_ok   = start && ((state_q == IDLE) || (state_q == DONE) ||
                                  (state_q == ERROR));
    assign pack_valid = xfer && (state_q == PAYLOAD);
    assign count_n    = {count_q[15:8], in_data};
    assign last_word  = (16'(word_idx_q) == (count_q - 16'd1));

    byte_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (start_ok),
        .byte_valid (pack_valid),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and state-decoded status outputs.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a variable unassigned, which would infer a latch.
        state_d   = state_q;
        core_hold = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) state_d = CNT_HI;
            end
            CNT_HI: begin
                core_hold = 1'b1;
                if (xfer) state_d = CNT_LO;
            end
            CNT_LO: begin
                core_hold = 1'b1;
                if (xfer) begin
                    if (count_n == 16'd0)                   state_d = CHECK;
                    else if ({1'b0, count_n} > DEPTH_EXT)   state_d = ERROR;
                    else                                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                core_hold = 1'b1;
                if (word_valid && last_word) state_d = CHECK;
            end
            CHECK: begin
                core_hold = 1'b1;
                if (xfer) state_d = (in_data == cksum_q) ? DONE : ERROR;
            end
            DONE: begin
                done = 1'b1;
                if (start_ok) state_d = CNT_HI;
            end
            ERROR: begin
                error     = 1'b1;
                core_hold = 1'b1;
                if (start_ok) state_d = CNT_HI;
            end
            default: state_d = IDLE;
        endcase
    end

    // Count capture, checksum, word index and the registered write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q     <= '0;
            word_idx_q  <= '0;
            cksum_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= word_valid;
            if (start_ok) begin
                count_q    <= '0;
                word_idx_q <= '0;
                cksum_q    <= '0;
            end
            if (xfer && (state_q == CNT_HI)) count_q[15:8] <= in_data;
            if (xfer && (state_q == CNT_LO)) count_q[7:0]  <= in_data;
            if (pack_valid) cksum_q <= cksum_q ^ in_data;
            if (word_valid) begin
                mem_addr_q  <= word_idx_q;
                mem_wdata_q <= word;
                word_idx_q  <= word_idx_q + 1'b1;
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized
// images, all checked against an image-format reference model.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_hold;
    logic              done;
    logic              error;

    int tests = 0;
    int fails = 0;

    logic [7:0]  stim[$];
    logic [39:0] exp_w[$];
    logic [39:0] obs_w[$];
    bit          exp_done, exp_err;
    bit          timed_out;
    logic        hold_after_start;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_hold (core_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    // Record every memory write as {addr, data}, sampled mid-cycle.
    always @(negedge clock) begin
        if (mem_we === 1'b1) obs_w.push_back({mem_addr, mem_wdata});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1, "watchdog");
    end

    // Reference model: interpret the image by its format rules.
    task automatic model(input logic [7:0] s[$]);
        int    n;
        logic [7:0] x;
        exp_w = {};
        exp_done = 0;
        exp_err = 0;
        n = int'(s[0]) * 256 + int'(s[1]);
        if (n > DEPTH) begin
            exp_err = 1;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            w = {s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]};
            exp_w.push_back({8'(i), w});
            for (int k = 0; k < 4; k++) x = x ^ s[2+4*i+k];
        end
        if (s[2+4*n] == x) exp_done = 1;
        else               exp_err  = 1;
    endtask

    task automatic make_stream(input int n, input bit bad);
        logic [7:0] x;
        stim = {};
        stim.push_back(8'(n >> 8));
        stim.push_back(8'(n));
        if (n > DEPTH) return;
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            stim.push_back(b);
            x = x ^ b;
        end
        if (bad) x = x ^ 8'(1 + $urandom_range(0, 254));
        stim.push_back(x);
    endtask

    function automatic bit writes_equal();
        if (obs_w.size() != exp_w.size()) return 0;
        foreach (exp_w[i]) if (obs_w[i] !== exp_w[i]) return 0;
        return 1;
    endfunction

    // Drive one load: start pulse then the byte stream (optionally with a
    // one-cycle gap after every byte, optionally a start pulse on byte busy_idx).
    task automatic do_load(input logic [7:0] s[$], input bit throttle, input int busy_idx);
        int t;
        obs_w = {};
        timed_out = 0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        hold_after_start = core_hold;
        foreach (s[i]) begin
            in_valid = 1'b1;
            in_data  = s[i];
            if (i == busy_idx) start = 1'b1;
            t = 0;
            while (in_ready !== 1'b1 && t < 20) begin
                @(negedge clock);
                t++;
            end
            if (in_ready !== 1'b1) begin
                timed_out = 1;
                in_valid = 1'b0;
                start = 1'b0;
                return;
            end
            @(negedge clock);
            in_valid = 1'b0;
            start = 1'b0;
            in_data = 8'($urandom);
            if (throttle) @(negedge clock);
        end
    endtask

    task automatic check_load_result(input string name);
        tests++;
        if (timed_out !== 1'b0) begin
            fails++;
            $display("FAIL %s timeout: in_ready stayed low, got %0b want 0", name, timed_out);
        end
        tests++;
        if (!writes_equal()) begin
            fails++;
            $display("FAIL %s writes: got %0d writes (first %h) want %0d (first %h)", name,
                     obs_w.size(), (obs_w.size() > 0) ? obs_w[0] : 40'h0,
                     exp_w.size(), (exp_w.size() > 0) ? exp_w[0] : 40'h0);
        end
        tests++;
        if (done !== exp_done || error !== exp_err) begin
            fails++;
            $display("FAIL %s status: got done=%b error=%b want done=%b error=%b",
                     name, done, error, exp_done, exp_err);
        end
        tests++;
        if (core_hold !== exp_err) begin
            fails++;
            $display("FAIL %s core_hold: got %b want %b", name, core_hold, exp_err);
        end
        tests++;
        if (hold_after_start !== 1'b1) begin
            fails++;
            $display("FAIL %s hold_after_start: got %b want 1", name, hold_after_start);
        end
        tests++;
        if (in_ready !== 1'b0 || mem_we !== 1'b0) begin
            fails++;
            $display("FAIL %s idle_outputs: got in_ready=%b mem_we=%b want 0 0", name, in_ready, mem_we);
        end
        if (exp_w.size() > 0) begin
            tests++;
            if ({mem_addr, mem_wdata} !== exp_w[exp_w.size()-1]) begin
                fails++;
                $display("FAIL %s held_write_port: got %h want %h", name,
                         {mem_addr, mem_wdata}, exp_w[exp_w.size()-1]);
            end
        end
    endtask

    function automatic void nominal_stream();
        stim = '{8'h00, 8'h02, 8'h7C, 8'h22, 8'h1A, 8'h14,
                 8'h48, 8'h00, 8'h00, 8'h04, 8'h1C};
    endfunction

    task automatic test_reset();
        tests++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, core_hold, done, error} !== '0) begin
            fails++;
            $display("FAIL reset_values: got ready=%b we=%b addr=%h data=%h hold=%b done=%b err=%b want all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, core_hold, done, error);
        end
    endtask

    task automatic test_nominal();
        nominal_stream();
        model(stim);
        tests++;
        if (exp_w.size() != 2 || exp_w[0] !== {8'h00, 32'h7C221A14} ||
            exp_w[1] !== {8'h01, 32'h48000004} || !exp_done) begin
            fails++;
            $display("FAIL nominal_model: got %0d words want 2 with 7C221A14/48000004", exp_w.size());
        end
        do_load(stim, 0, -1);
        check_load_result("nominal");
    endtask

    task automatic test_bad_checksum();
        nominal_stream();
        stim[10] = 8'h1D;
        model(stim);
        do_load(stim, 0, -1);
        check_load_result("bad_checksum");
    endtask

    task automatic test_zero_count();
        stim = '{8'h00, 8'h00, 8'h00};
        model(stim);
        do_load(stim, 0, -1);
        check_load_result("zero_count");
    endtask

    task automatic test_oversize();
        stim = '{8'h01, 8'h01};
        model(stim);
        do_load(stim, 0, -1);
        check_load_result("oversize");
        in_valid = 1'b1;
        repeat (3) @(negedge clock);
        tests++;
        if (in_ready !== 1'b0 || error !== 1'b1 || obs_w.size() != 0) begin
            fails++;
            $display("FAIL oversize_stays: got in_ready=%b error=%b writes=%0d want 0 1 0",
                     in_ready, error, obs_w.size());
        end
        in_valid = 1'b0;
    endtask

    task automatic test_depth_boundary();
        make_stream(DEPTH, 0);
        model(stim);
        do_load(stim, 0, -1);
        check_load_result("depth_boundary");
    endtask

    task automatic test_throttled();
        nominal_stream();
        model(stim);
        do_load(stim, 1, -1);
        check_load_result("throttled");
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] part[$];
        nominal_stream();
        part = stim[0:5];
        do_load(part, 0, -1);
        reset = 1'b1;
        @(negedge clock);
        tests++;
        if (core_hold !== 1'b0 || in_ready !== 1'b0 || mem_we !== 1'b0 ||
            done !== 1'b0 || error !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_load: got hold=%b ready=%b we=%b done=%b err=%b want all 0",
                     core_hold, in_ready, mem_we, done, error);
        end
        reset = 1'b0;
        @(negedge clock);
        model(stim);
        do_load(stim, 0, -1);
        check_load_result("reload_after_reset");
    endtask

    task automatic test_start_busy();
        nominal_stream();
        model(stim);
        do_load(stim, 0, 4);
        check_load_result("start_busy");
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            int  n;
            bit  bad;
            bit  thr;
            n   = ($urandom_range(0, 9) == 0) ? DEPTH + 1 + $urandom_range(0, 500)
                                              : $urandom_range(0, 8);
            bad = ($urandom_range(0, 3) == 0);
            thr = $urandom_range(0, 1) == 1;
            make_stream(n, bad);
            model(stim);
            do_load(stim, thr, -1);
            check_load_result($sformatf("random%0d_n%0d", it, n));
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_zero_count();
        test_oversize();
        test_depth_boundary();
        test_throttled();
        test_reset_mid_load();
        test_start_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
